udp_frame_tx: RTL and testbench
===============================

Name: udp_frame_tx

Overview:
Builds and transmits one Ethernet II / IPv4 / UDP frame per request over a 4-bit MII-style nibble interface. It is the transmit counterpart of the board's UDP receive path. User payload is pulled as 32-bit words through a request/response handshake. The block inserts the preamble/SFD, all headers, the IP header checksum, zero padding and the CRC-32 FCS, so its output can be looped directly into the receive path.

Parameters:
BOARD_MAC, 48'h12_34_56_78_9A_BC, source MAC
BOARD_IP, {8'd169,8'd254,8'd1,8'd23}, source IP
BOARD_PORT, 16'd1234, UDP source port
DES_MAC, 48'hFF_FF_FF_FF_FF_FF, destination MAC
DES_IP, {8'd169,8'd254,8'd1,8'd100}, destination IP
DES_PORT, 16'd1234, UDP destination port

Ports:
eth_rx_clk  in  1  clock (all logic, including tx nibbles, runs on this clock)
sys_rst_n  in  1  reset, asynchronous, active-low
send_en  in  1  start pulse; sampled only in IDLE
send_data_num  in  16  payload byte count; captured on send_en; values >1472 clamp to 1472
send_data  in  32  payload word; byte [31:24] is sent first
read_data_req  out  1  one-cycle pulse requesting the next payload word
send_end  out  1  one-cycle pulse: frame finished
eth_tx_en  out  1  nibble valid
eth_tx_data  out  4  nibble; low nibble of each byte first

Behaviour:
- Reset: every output is 0, FSM is in IDLE, IP identification counter is 0. Reset asserted mid-frame aborts immediately; eth_tx_en drops asynchronously.
- All outputs are registered.
- FSM states: IDLE -> CHECK_SUM (3 cycles) -> PREAMBLE (16 nibbles: 7x55, D5) -> ETH_HEAD (28 nibbles) -> IP_UDP_HEAD (56 nibbles) -> SEND_DATA (2*max(N,18) nibbles) -> CRC (8 nibbles) -> IDLE.
- N is the clamped send_data_num. send_en outside IDLE is ignored.
- CHECK_SUM sequence:
  - cycle 1: 32-bit sum of the ten 16-bit IP header words, with the checksum field taken as 0.
  - cycle 2: fold carry, sum[15:0]+sum[31:16].
  - cycle 3: fold again, then invert.
  - The first preamble nibble, with eth_tx_en=1, appears in the cycle after CHECK_SUM completes, i.e. 4 cycles after send_en.
- Ethernet header: DES_MAC, BOARD_MAC, type 0x0800.
- IP header:
  - version/IHL 0x45, TOS 0x00, total length 28+N
  - identification = counter, which increments by 1 at send_end and wraps at 0xFFFF
  - flags/offset 0x4000, TTL 0x40, protocol 0x11
  - checksum, BOARD_IP, DES_IP
- UDP header: BOARD_PORT, DES_PORT, length 8+N, checksum 0x0000.
- Payload:
  - Bytes 0..N-1 come from fetched words; unused trailing bytes of the last word are discarded.
  - If N<18, zero bytes pad the payload to 18 bytes. Padding is not counted in the IP or UDP lengths.
- Word handshake:
  - ceil(N/4) read_data_req pulses are issued. A pulse in cycle t means send_data is valid at the eth_rx_clk edge ending cycle t+1.
  - Byte 0 of that word drives eth_tx_data in cycle t+2.
  - The first pulse falls 2 cycles before the first payload nibble. Each subsequent pulse falls 2 cycles before the next word's first nibble, so streaming is gapless.
  - N=0: no pulses.
- FCS:
  - CRC-32 reflected, polynomial 0x04C11DB7, init 0xFFFFFFFF.
  - Updated one nibble per cycle over the destination MAC through the last pad byte.
  - Transmitted complemented, LSB nibble first.
- Frame end: eth_tx_en deasserts after the 8th CRC nibble. send_end pulses in that same first idle cycle. The next send_en is accepted from the following cycle.
- Total eth_tx_en cycles = 16 + 2*(42+max(N,18)) + 8.

Test Plan:
- N=4, send_data=0x01020304, on send_en:
  - exactly 1 read_data_req.
  - 144 eth_tx_en cycles.
  - bytes after SFD: DES_MAC, BOARD_MAC, 08 00, 45 00 00 20 00 00 40 00 40 11; UDP length 0x000C.
  - payload 01 02 03 04 followed by 14 bytes of 00.
  - FCS matches a software CRC-32 model.
- N=40, incrementing words: 10 req pulses with no gap in eth_tx_en. Loopback into the receive path yields rec_data sequence identical to the words sent and rec_end on the last word.
- IP checksum: compare against a one's-complement model for N=1, 28 and 1472. Back-to-back frames show identification 0, 1, 2 with correct per-frame checksum.
- send_en pulsed mid-frame: ignored, and frame bytes are unchanged. N=0: no req pulses, 18 zero payload bytes, 144 cycles.
- Reset mid-payload: eth_tx_en=0 and all outputs 0 immediately. After release, a new send_en produces a complete frame with identification 0.
- N=2000: clamped to 1472, giving IP total length 0x05DC and 368 req pulses.

Source files
------------

// File: rtl/udp_frame_tx.sv
// Ethernet II / IPv4 / UDP frame transmitter over a 4-bit MII nibble bus.
// Pulls payload as 32-bit words, inserts preamble, headers, IP checksum, padding and FCS.
module udp_frame_tx #(
    parameter logic [47:0] BOARD_MAC  = 48'h12_34_56_78_9A_BC,
    parameter logic [31:0] BOARD_IP   = {8'd169, 8'd254, 8'd1, 8'd23},
    parameter logic [15:0] BOARD_PORT = 16'd1234,
    parameter logic [47:0] DES_MAC    = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] DES_IP     = {8'd169, 8'd254, 8'd1, 8'd100},
    parameter logic [15:0] DES_PORT   = 16'd1234
) (
    input  logic        eth_rx_clk,
    input  logic        sys_rst_n,
    input  logic        send_en,
    input  logic [15:0] send_data_num,
    input  logic [31:0] send_data,
    output logic        read_data_req,
    output logic        send_end,
    output logic        eth_tx_en,
    output logic [3:0]  eth_tx_data
);

    typedef enum logic [2:0] {
        IDLE, CHECK_SUM, PREAMBLE, ETH_HEAD, IP_UDP_HEAD, SEND_DATA, CRC
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [10:0] n_q, n_d;
    logic [11:0] dlen_q, dlen_d;
    logic [15:0] id_q, id_d;
    logic [31:0] sum_q, sum_d;
    logic [15:0] cks_q, cks_d;
    logic [31:0] word_q, word_d;
    logic [31:0] crc_q, crc_d;
    logic        tx_en_q, tx_en_d;
    logic [3:0]  tx_data_q, tx_data_d;
    logic        req_q, req_d;
    logic        end_q, end_d;

    logic [15:0]  ip_len, udp_len;
    logic [335:0] hdr;
    logic [31:0]  hdr_sum;

    assign ip_len  = 16'd28 + {5'd0, n_q};
    assign udp_len = 16'd8 + {5'd0, n_q};

    assign hdr = {DES_MAC, BOARD_MAC, 16'h0800,
                  16'h4500, ip_len, id_q, 16'h4000, 16'h4011, cks_q, BOARD_IP, DES_IP,
                  BOARD_PORT, DES_PORT, udp_len, 16'h0000};

    assign hdr_sum = 32'h4500 + {16'd0, ip_len} + {16'd0, id_q} + 32'h4000 + 32'h4011
                   + {16'd0, BOARD_IP[31:16]} + {16'd0, BOARD_IP[15:0]}
                   + {16'd0, DES_IP[31:16]} + {16'd0, DES_IP[15:0]};

    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c ^ {28'd0, d};
        for (int unsigned i = 0; i < 4; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 12'd1;
        n_d     = n_q;
        dlen_d  = dlen_q;
        id_d    = id_q;
        sum_d   = sum_q;
        cks_d   = cks_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (send_en && !end_q) begin
                    state_d = CHECK_SUM;
                    n_d     = (send_data_num > 16'd1472) ? 11'd1472 : send_data_num[10:0];
                    dlen_d  = (n_d < 11'd18) ? 12'd36 : {n_d, 1'b0};
                end
            end
            CHECK_SUM: begin
                if (cnt_q == 12'd0) begin
                    sum_d = hdr_sum;
                end else if (cnt_q == 12'd1) begin
                    sum_d = {16'd0, sum_q[15:0]} + {16'd0, sum_q[31:16]};
                end else begin
                    // After the first fold the upper half is tiny, so a 16-bit add cannot carry.
                    cks_d   = ~(sum_q[15:0] + sum_q[31:16]);
                    state_d = PREAMBLE;
                    cnt_d   = '0;
                end
            end
            PREAMBLE:    if (cnt_q == 12'd15) begin state_d = ETH_HEAD;    cnt_d = '0; end
            ETH_HEAD:    if (cnt_q == 12'd27) begin state_d = IP_UDP_HEAD; cnt_d = '0; end
            IP_UDP_HEAD: if (cnt_q == 12'd55) begin state_d = SEND_DATA;   cnt_d = '0; end
            SEND_DATA:   if (cnt_q == dlen_q - 12'd1) begin state_d = CRC; cnt_d = '0; end
            CRC: begin
                if (cnt_q == 12'd7) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    id_d    = id_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output registers are loaded from the next position so they line up with state_q.
    logic [5:0]  hb;
    logic [31:0] cur_word;
    logic [7:0]  byte_v;
    logic [31:0] fcs;

    always_comb begin
        hb        = '0;
        byte_v    = '0;
        tx_data_d = '0;
        cur_word  = word_q;
        word_d    = word_q;
        fcs       = ~crc_q;
        if (state_d == SEND_DATA && cnt_d[2:0] == 3'd0) begin
            cur_word = send_data;
            word_d   = send_data;
        end
        case (state_d)
            PREAMBLE: tx_data_d = (cnt_d == 12'd15) ? 4'hD : 4'h5;
            ETH_HEAD, IP_UDP_HEAD: begin
                hb        = (state_d == ETH_HEAD) ? cnt_d[6:1] : cnt_d[6:1] + 6'd14;
                byte_v    = hdr[{6'd41 - hb, 3'b000} +: 8];
                tx_data_d = cnt_d[0] ? byte_v[7:4] : byte_v[3:0];
            end
            SEND_DATA: begin
                byte_v    = (cnt_d[11:1] < n_q) ? cur_word[{~cnt_d[2:1], 3'b000} +: 8] : 8'd0;
                tx_data_d = cnt_d[0] ? byte_v[7:4] : byte_v[3:0];
            end
            CRC: tx_data_d = fcs[{cnt_d[2:0], 2'b00} +: 4];
            default: tx_data_d = '0;
        endcase

        crc_d = crc_q;
        if (state_d == PREAMBLE) begin
            crc_d = '1;
        end else if (state_d inside {ETH_HEAD, IP_UDP_HEAD, SEND_DATA}) begin
            crc_d = crc_nib(crc_q, tx_data_d);
        end

        tx_en_d = state_d inside {PREAMBLE, ETH_HEAD, IP_UDP_HEAD, SEND_DATA, CRC};
        end_d   = (state_q == CRC) && (cnt_q == 12'd7);
        req_d   = ((state_d == IP_UDP_HEAD) && (cnt_d == 12'd54) && (n_q != 11'd0))
               || ((state_d == SEND_DATA) && (cnt_d[2:0] == 3'd6) && ((cnt_d[11:1] + 11'd1) < n_q));
    end

    always_ff @(posedge eth_rx_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            n_q       <= '0;
            dlen_q    <= '0;
            id_q      <= '0;
            sum_q     <= '0;
            cks_q     <= '0;
            word_q    <= '0;
            crc_q     <= '1;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            req_q     <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            dlen_q    <= dlen_d;
            id_q      <= id_d;
            sum_q     <= sum_d;
            cks_q     <= cks_d;
            word_q    <= word_d;
            crc_q     <= crc_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            req_q     <= req_d;
            end_q     <= end_d;
        end
    end

    assign read_data_req = req_q;
    assign send_end      = end_q;
    assign eth_tx_en     = tx_en_q;
    assign eth_tx_data   = tx_data_q;

endmodule

// File: tb/tb_udp_frame_tx.sv
// Directed bench for udp_frame_tx: captures each transmitted frame and checks it
// against a byte-level header, one's-complement checksum and CRC-32 model.
module tb_udp_frame_tx;

    logic        eth_rx_clk = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        send_en    = 1'b0;
    logic [15:0] send_data_num = '0;
    logic [31:0] send_data  = '0;
    logic        read_data_req;
    logic        send_end;
    logic        eth_tx_en;
    logic [3:0]  eth_tx_data;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] exp_id      = '0;
    logic [7:0]  frame[$];
    logic [7:0]  hb[0:41];

    always #5 eth_rx_clk = ~eth_rx_clk;

    udp_frame_tx dut (
        .eth_rx_clk    (eth_rx_clk),
        .sys_rst_n     (sys_rst_n),
        .send_en       (send_en),
        .send_data_num (send_data_num),
        .send_data     (send_data),
        .read_data_req (read_data_req),
        .send_end      (send_end),
        .eth_tx_en     (eth_tx_en),
        .eth_tx_data   (eth_tx_data)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input int k, input int mode);
        logic [31:0] kk;
        kk = k;
        case (mode)
            0:       return 32'h0102_0304;
            1:       return 32'h1020_3000 + kk;
            default: return (kk * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        endcase
    endfunction

    function automatic logic [7:0] pay_byte(input int i, input int n, input int mode);
        logic [31:0] w;
        if (i >= n) return 8'h00;
        w = word_of(i / 4, mode);
        w = w << (8 * (i % 4));
        return w[31:24];
    endfunction

    task automatic build_hdr(input int n, input logic [15:0] id);
        logic [335:0] v;
        logic [31:0]  s;
        logic [15:0]  ck;
        logic [15:0]  ln, ul;
        ln = 16'(28 + n);
        ul = 16'(8 + n);
        v = {48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC, 16'h0800,
             16'h4500, ln, id, 16'h4000, 16'h4011, 16'h0000,
             32'hA9FE_0117, 32'hA9FE_0164,
             16'h04D2, 16'h04D2, ul, 16'h0000};
        for (int i = 0; i < 42; i++) hb[i] = v[335 - 8 * i -: 8];
        s = '0;
        for (int w = 0; w < 10; w++) s = s + {16'd0, hb[14 + 2 * w], hb[15 + 2 * w]};
        while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        ck = ~s[15:0];
        hb[24] = ck[15:8];
        hb[25] = ck[7:0];
    endtask

    function automatic logic [31:0] crc_range(input int first, input int last);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = first; i <= last; i++) begin
            c = c ^ {24'd0, frame[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic run_frame(input int num, input int mode, input int glitch_at, input int rst_at);
        int n, p, tot, cyc, nreq, ntx, lat, nend, widx;
        bit done, seen, phase;
        logic [3:0]  lo;
        logic [31:0] fcs;
        n = (num > 1472) ? 1472 : num;
        p = (n < 18) ? 18 : n;
        tot = 8 + 42 + p + 4;
        cyc = 0; nreq = 0; ntx = 0; lat = -1; nend = 0; widx = 0;
        done = 0; seen = 0; phase = 0; lo = '0;
        frame.delete();

        @(negedge eth_rx_clk);
        send_data_num = 16'(num);
        send_en = 1'b1;
        @(posedge eth_rx_clk);
        #1 send_en = 1'b0;

        while (!done && cyc < 6000) begin
            @(negedge eth_rx_clk);
            cyc++;
            send_en = (cyc == glitch_at);
            if (cyc == glitch_at) send_data_num = 16'd7;
            if (cyc == rst_at) begin
                check_val("tx_en_before_rst", 32'(eth_tx_en), 32'd1);
                sys_rst_n = 1'b0;
                #1;
                check_val("rst_tx_en", 32'(eth_tx_en), 32'd0);
                check_val("rst_tx_data", 32'(eth_tx_data), 32'd0);
                check_val("rst_req", 32'(read_data_req), 32'd0);
                check_val("rst_end", 32'(send_end), 32'd0);
                repeat (2) @(negedge eth_rx_clk);
                sys_rst_n = 1'b1;
                send_data = '0;
                exp_id = '0;
                return;
            end
            if (read_data_req) begin
                nreq++;
                send_data = word_of(widx, mode);
                widx++;
            end
            if (send_end) nend++;
            if (eth_tx_en) begin
                if (lat < 0) lat = cyc;
                seen = 1;
                ntx++;
                if (!phase) lo = eth_tx_data;
                else frame.push_back({eth_tx_data, lo});
                phase = ~phase;
            end else if (seen) begin
                done = 1;
                check_val("send_end_pos", 32'(send_end), 32'd1);
            end
        end
        check_val("frame_done", 32'(done), 32'd1);
        check_val("tx_cycles", 32'(ntx), 32'(16 + 2 * (42 + p) + 8));
        check_val("req_count", 32'(nreq), 32'((n + 3) / 4));
        check_val("first_tx_latency", 32'(lat), 32'd4);
        check_val("send_end_count", 32'(nend), 32'd1);
        check_val("frame_bytes", 32'(frame.size()), 32'(tot));
        if (frame.size() == tot) begin
            for (int i = 0; i < 8; i++)
                check_val($sformatf("pre[%0d]", i), 32'(frame[i]), (i == 7) ? 32'hD5 : 32'h55);
            build_hdr(n, exp_id);
            for (int i = 0; i < 42; i++)
                check_val($sformatf("hdr[%0d]", i), 32'(frame[8 + i]), 32'(hb[i]));
            for (int i = 0; i < p; i++)
                check_val($sformatf("pay[%0d]", i), 32'(frame[50 + i]), 32'(pay_byte(i, n, mode)));
            fcs = ~crc_range(8, 50 + p - 1);
            for (int j = 0; j < 4; j++)
                check_val($sformatf("fcs[%0d]", j), 32'(frame[50 + p + j]), 32'(fcs[8 * j +: 8]));
        end
        exp_id = exp_id + 16'd1;
    endtask

    initial begin
        repeat (3) @(negedge eth_rx_clk);
        check_val("rst_state_tx_en", 32'(eth_tx_en), 32'd0);
        check_val("rst_state_data", 32'(eth_tx_data), 32'd0);
        check_val("rst_state_req", 32'(read_data_req), 32'd0);
        check_val("rst_state_end", 32'(send_end), 32'd0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge eth_rx_clk);

        run_frame(4, 0, 0, 0);
        if (frame.size() > 51) begin
            check_val("hand_ip_len", 32'({frame[24], frame[25]}), 32'h0020);
            check_val("hand_ip_cks", 32'({frame[32], frame[33]}), 32'hE455);
            check_val("hand_udp_len", 32'({frame[46], frame[47]}), 32'h000C);
            check_val("hand_pay0", 32'({frame[50], frame[51]}), 32'h0102);
        end

        // Back-to-back frames: identification 1, 2, 3.
        run_frame(1, 2, 0, 0);
        run_frame(28, 2, 0, 0);
        run_frame(1472, 1, 0, 0);
        run_frame(40, 1, 0, 0);
        run_frame(0, 0, 0, 0);
        run_frame(12, 2, 60, 0);

        // Reset lands inside the payload of a 40-byte frame.
        run_frame(40, 1, 0, 150);
        run_frame(4, 0, 0, 0);
        if (frame.size() > 33) begin
            check_val("hand_id_after_rst", 32'({frame[26], frame[27]}), 32'h0000);
            check_val("hand_cks_after_rst", 32'({frame[32], frame[33]}), 32'hE455);
        end

        run_frame(2000, 2, 0, 0);
        if (frame.size() > 25)
            check_val("hand_clamp_len", 32'({frame[24], frame[25]}), 32'h05DC);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
